// File: rtl/uart_rx_oversampler.sv
// UART receiver driven by a 16x-baud tick: samples mid-bit, deserialises LSB-first, hands bytes out on valid/ready.
// Define UART_RX_PARITY_EN to add a parity bit between payload and stop bit (ports parity_odd, parity_err).
`timescale 1ns/1ps
module uart_rx_oversampler #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 os_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 overrun
`ifdef UART_RX_PARITY_EN
  ,
  input  logic                 parity_odd,
  output logic                 parity_err
`endif
);

  // Handshake: rx_valid/rx_data hold until an edge with rx_valid && rx_ready;
  // rx_ready while rx_valid=0 has no effect.

  localparam logic [3:0] MID      = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] LAST     = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] BIT_LAST = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   wrap;
  logic [3:0]             cnt_inc;
`ifdef UART_RX_PARITY_EN
  logic                   par_bad_q, par_bad_d;
  logic                   parity_err_q, parity_err_d;
`endif

  // Synchroniser presets to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '1;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end

  assign rx_s    = sync_q[SYNC_STAGES-1];
  assign wrap    = (cnt_q == LAST);
  assign cnt_inc = wrap ? 4'd0 : cnt_q + 4'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    data_d       = data_q;
    valid_d      = valid_q & ~rx_ready;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif
    if (os_tick) begin
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            cnt_d   = '0;
            state_d = START;
          end
        end
        START: begin
          // A start bit must still be low at its centre, otherwise it was a glitch.
          if (cnt_q == MID) begin
            cnt_d = '0;
            if (rx_s) begin
              state_d = IDLE;
            end else begin
              bit_cnt_d = '0;
              state_d   = DATA;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        DATA: begin
          cnt_d = cnt_inc;
          if (wrap) begin
            shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          cnt_d = cnt_inc;
          if (wrap) begin
            par_bad_d = rx_s ^ (^shift_q) ^ parity_odd;
            state_d   = STOP;
          end
        end
`endif
        STOP: begin
          cnt_d = cnt_inc;
          if (wrap) begin
            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
            parity_err_d = par_bad_q;
`endif
            if (rx_s) begin
              data_d    = shift_q;
              valid_d   = 1'b1;
              overrun_d = valid_q & ~rx_ready;
            end else begin
              frame_err_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign rx_busy   = (state_q != IDLE);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// Bench for uart_rx_oversampler: directed scenarios plus randomized frames against a sample-schedule model.
`timescale 1ns/1ps
module tb_uart_rx_oversampler;
  localparam int DATA_BITS   = 8;
  localparam int OVERSAMPLE  = 16;
  localparam int SYNC_STAGES = 2;
  localparam int MID         = OVERSAMPLE / 2 - 1;

  logic                 clk;
  logic                 rst;
  logic                 os_tick;
  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 rx_busy;
  logic                 frame_err;
  logic                 overrun;
`ifdef UART_RX_PARITY_EN
  logic                 parity_odd;
  logic                 parity_err;
  logic                 par_flip;
`endif

  uart_rx_oversampler #(
    .DATA_BITS(DATA_BITS), .OVERSAMPLE(OVERSAMPLE), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .rst(rst), .os_tick(os_tick), .rx(rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_busy(rx_busy), .frame_err(frame_err), .overrun(overrun)
`ifdef UART_RX_PARITY_EN
    , .parity_odd(parity_odd), .parity_err(parity_err)
`endif
  );

  // ---------------- clock / tick / ready generation ----------------
  int tick_div   = 16;
  int ready_mode = 1;  // 0: low, 1: high, 2: random

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    os_tick = 1'b0;
    forever begin
      repeat (tick_div - 1) @(negedge clk);
      os_tick = 1'b1;
      @(negedge clk);
      if (tick_div > 1) os_tick = 1'b0;
    end
  end

  initial begin
    rx_ready = 1'b0;
    forever begin
      @(negedge clk);
      rx_ready = (ready_mode == 1) ? 1'b1 :
                 (ready_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // ---------------- scoreboard bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [DATA_BITS-1:0] exp_q[$];
  bit sb_en = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  // Samples are taken at tick MID+1+OVERSAMPLE*k after the tick that saw the
  // line low: k=0 start, 1..DATA_BITS payload, then (parity,) stop.
  logic [SYNC_STAGES-1:0] m_hist  = '1;
  bit                     m_active = 1'b0;
  int                     m_ticks = 0;
  int                     m_k;
  logic [DATA_BITS-1:0]   m_bits  = '0;
  logic                   m_valid = 1'b0;
  logic [DATA_BITS-1:0]   m_data  = '0;
  logic                   m_par_bad = 1'b0;
  logic                   exp_fe, exp_ov, exp_pe;
  logic                   rs;
  logic [DATA_BITS-1:0]   exp_b;
  logic                   prev_valid = 1'b0;
  logic [DATA_BITS-1:0]   prev_data  = '0;
  int n_acc = 0, n_fe = 0, n_ov = 0, n_pe = 0;
  logic [DATA_BITS-1:0]   last_acc = '0;

  always @(posedge clk) begin
    #1;
    exp_fe = 1'b0;
    exp_ov = 1'b0;
    exp_pe = 1'b0;
    if (!rst) begin
      m_hist   = '1;
      m_active = 1'b0;
      m_ticks  = 0;
      m_bits   = '0;
      m_valid  = 1'b0;
      m_data   = '0;
      m_par_bad = 1'b0;
      exp_q.delete();
    end else begin
      if (prev_valid && rx_ready) begin
        n_acc++;
        last_acc = prev_data;
      end
      rs     = m_hist[SYNC_STAGES-1];
      m_hist = {m_hist[SYNC_STAGES-2:0], rx};
      if (m_valid && rx_ready) m_valid = 1'b0;
      if (os_tick) begin
        if (!m_active) begin
          if (!rs) begin
            m_active = 1'b1;
            m_ticks  = 0;
          end
        end else begin
          m_ticks++;
          if (m_ticks >= MID + 1 && (m_ticks - (MID + 1)) % OVERSAMPLE == 0) begin
            m_k = (m_ticks - (MID + 1)) / OVERSAMPLE;
            if (m_k == 0) begin
              if (rs) m_active = 1'b0;
            end else if (m_k <= DATA_BITS) begin
              m_bits[m_k-1] = rs;
`ifdef UART_RX_PARITY_EN
            end else if (m_k == DATA_BITS + 1) begin
              m_par_bad = rs ^ (^m_bits) ^ parity_odd;
`endif
            end else begin
              m_active = 1'b0;
              exp_pe   = m_par_bad;
              if (rs) begin
                exp_ov  = m_valid;
                m_valid = 1'b1;
                m_data  = m_bits;
              end else begin
                exp_fe = 1'b1;
              end
              if (sb_en) begin
                if (exp_q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL sb_byte at %0t: frame completed with no byte queued", $time);
                end else begin
                  exp_b = exp_q.pop_front();
                  chk("sb_byte", 32'(m_bits), 32'(exp_b));
                end
              end
            end
          end
        end
      end
    end
    chk("rx_valid",  32'(rx_valid),  32'(m_valid));
    chk("rx_data",   32'(rx_data),   32'(m_data));
    chk("rx_busy",   32'(rx_busy),   32'(m_active));
    chk("frame_err", 32'(frame_err), 32'(exp_fe));
    chk("overrun",   32'(overrun),   32'(exp_ov));
`ifdef UART_RX_PARITY_EN
    chk("parity_err", 32'(parity_err), 32'(exp_pe));
    if (rst && parity_err) n_pe++;
`endif
    if (rst && frame_err) n_fe++;
    if (rst && overrun)   n_ov++;
    prev_valid = rx_valid;
    prev_data  = rx_data;
  end

  // ---------------- driver tasks ----------------
  task automatic send_bit(input logic b);
    rx = b;
    repeat (OVERSAMPLE * tick_div) @(negedge clk);
  endtask

  task automatic idle(input int nbits);
    rx = 1'b1;
    repeat (nbits * OVERSAMPLE * tick_div) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DATA_BITS-1:0] d, input logic stop);
    exp_q.push_back(d);
    send_bit(1'b0);
    for (int i = 0; i < DATA_BITS; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ parity_odd ^ par_flip);
`endif
    send_bit(stop);
  endtask

  // ---------------- test sequence ----------------
  int b_acc, b_fe, b_ov, b_pe;
  logic [DATA_BITS-1:0] rnd_d;
  logic rnd_stop;

  task automatic snap();
    b_acc = n_acc;
    b_fe  = n_fe;
    b_ov  = n_ov;
    b_pe  = n_pe;
  endtask

  initial begin
    rst = 1'b0;
    rx  = 1'b1;
`ifdef UART_RX_PARITY_EN
    parity_odd = 1'b0;
    par_flip   = 1'b0;
`endif
    repeat (4) @(negedge clk);
    chk("reset_valid", 32'(rx_valid), 0);
    chk("reset_data",  32'(rx_data),  0);
    chk("reset_busy",  32'(rx_busy),  0);
    chk("reset_fe",    32'(frame_err), 0);
    chk("reset_ov",    32'(overrun),  0);
    rst = 1'b1;
    idle(1);

    // single clean byte
    snap();
    send_frame(8'h55, 1'b1);
    idle(1);
    chk("t55_count", 32'(n_acc - b_acc), 1);
    chk("t55_data",  32'(last_acc), 32'h55);
    chk("t55_model", 32'(m_data), 32'h55);
    chk("t55_fe",    32'(n_fe - b_fe), 0);
    chk("t55_ov",    32'(n_ov - b_ov), 0);

    // start-bit glitch: 4 ticks low
    snap();
    rx = 1'b0;
    repeat (4 * tick_div) @(negedge clk);
    idle(2);
    chk("glitch_count", 32'(n_acc - b_acc), 0);
    chk("glitch_fe",    32'(n_fe - b_fe), 0);
    chk("glitch_busy",  32'(rx_busy), 0);

    // framing error then a good byte
    snap();
    send_frame(8'hA3, 1'b0);
    idle(1);
    send_frame(8'h3C, 1'b1);
    idle(1);
    chk("ferr_fe",    32'(n_fe - b_fe), 1);
    chk("ferr_count", 32'(n_acc - b_acc), 1);
    chk("ferr_data",  32'(last_acc), 32'h3C);

    // overrun with consumer stalled
    ready_mode = 0;
    snap();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(1);
    chk("ovr_ov",    32'(n_ov - b_ov), 1);
    chk("ovr_valid", 32'(rx_valid), 1);
    chk("ovr_data",  32'(rx_data), 32'h22);
    chk("ovr_noacc", 32'(n_acc - b_acc), 0);
    ready_mode = 1;
    idle(1);
    chk("ovr_count", 32'(n_acc - b_acc), 1);
    chk("ovr_last",  32'(last_acc), 32'h22);
    chk("ovr_clear", 32'(rx_valid), 0);

    // reset during bit 4 of 0xF0
    snap();
    rnd_d = 8'hF0;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(rnd_d[i]);
    rx = rnd_d[4];
    repeat (OVERSAMPLE * tick_div / 2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("mrst_valid", 32'(rx_valid), 0);
    chk("mrst_busy",  32'(rx_busy), 0);
    chk("mrst_data",  32'(rx_data), 0);
    rx  = 1'b1;
    rst = 1'b1;
    idle(1);
    send_frame(8'h0F, 1'b1);
    idle(1);
    chk("mrst_count", 32'(n_acc - b_acc), 1);
    chk("mrst_last",  32'(last_acc), 32'h0F);

    // break: line held low for three frame times
    tick_div = 4;
    idle(1);
    sb_en = 1'b0;
    snap();
    rx = 1'b0;
    repeat (3 * (DATA_BITS + 2) * OVERSAMPLE * tick_div) @(negedge clk);
    idle(12);
`ifndef UART_RX_PARITY_EN
    chk("break_fe", 32'(n_fe - b_fe), 3);
`endif
    exp_q.delete();
    sb_en = 1'b1;

`ifdef UART_RX_PARITY_EN
    tick_div = 16;
    idle(1);
    parity_odd = 1'b0;
    par_flip   = 1'b1;
    snap();
    send_frame(8'h07, 1'b1);
    idle(1);
    chk("par_bad_pe",   32'(n_pe - b_pe), 1);
    chk("par_bad_data", 32'(last_acc), 32'h07);
    par_flip = 1'b0;
    snap();
    send_frame(8'h07, 1'b1);
    idle(1);
    chk("par_ok_pe",    32'(n_pe - b_pe), 0);
    chk("par_ok_count", 32'(n_acc - b_acc), 1);
`endif

    // randomized frames
    ready_mode = 2;
    for (int blk = 0; blk < 3; blk++) begin
      tick_div = $urandom_range(1, 3);
      idle(2);
      for (int f = 0; f < 10; f++) begin
        rnd_d    = DATA_BITS'($urandom);
        rnd_stop = ($urandom_range(0, 7) != 0);
`ifdef UART_RX_PARITY_EN
        par_flip   = ($urandom_range(0, 4) == 0);
        parity_odd = 1'($urandom_range(0, 1));
`endif
        send_frame(rnd_d, rnd_stop);
        if (!rnd_stop) idle(1);
        else idle($urandom_range(0, 2));
      end
      idle(2);
    end
    chk("sb_leftover", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
